// File: rtl/ov7670_pixel_packer.sv
// OV7670 byte-stream capture: pairs camera bytes into RGB565 words tagged with a
// start-of-frame bit, validates frame geometry and drops whole frames on FIFO overflow.
module ov7670_pixel_packer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  p_data,
  input  logic        queue_full,
  output logic [16:0] queue_data,
  output logic        queue_wr_en,
  output logic        frame_done,
  output logic        overflow,
  output logic        line_error,
  output logic        frame_error,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {WAIT_INIT, WAIT_FRAME, CAPTURE, DROP} state_t;

  localparam logic [10:0] COL_W   = 11'(FRAME_WIDTH);
  localparam logic [10:0] COL_MAX = '1;
  localparam logic [9:0]  ROW_H   = 10'(FRAME_HEIGHT);
  localparam logic [9:0]  ROW_MAX = 10'(FRAME_HEIGHT + 1);

  state_t      state, state_nxt;
  logic        s_vsync, s_href, d_vsync, d_href;
  logic [7:0]  s_data;
  logic [7:0]  hi_byte, hi_byte_nxt;
  logic        have_hi, have_hi_nxt;
  logic        sof_armed, sof_nxt;
  logic [10:0] col, col_nxt;
  logic [9:0]  row, row_nxt, row_upd;
  logic [16:0] qd_nxt;
  logic        wr_nxt, fd_nxt, ovf_nxt, le_nxt, fe_nxt;
  logic [7:0]  fc_nxt;
  logic        vsync_fall, vsync_rise, href_fall;

  assign vsync_fall = d_vsync & ~s_vsync;
  assign vsync_rise = ~d_vsync & s_vsync;
  assign href_fall  = d_href & ~s_href;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_vsync <= 1'b0;
      s_href  <= 1'b0;
      s_data  <= '0;
      d_vsync <= 1'b0;
      d_href  <= 1'b0;
    end else begin
      s_vsync <= cam_vsync;
      s_href  <= cam_href;
      s_data  <= p_data;
      d_vsync <= s_vsync;
      d_href  <= s_href;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= WAIT_INIT;
      hi_byte     <= '0;
      have_hi     <= 1'b0;
      sof_armed   <= 1'b0;
      col         <= '0;
      row         <= '0;
      queue_data  <= '0;
      queue_wr_en <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      line_error  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      hi_byte     <= hi_byte_nxt;
      have_hi     <= have_hi_nxt;
      sof_armed   <= sof_nxt;
      col         <= col_nxt;
      row         <= row_nxt;
      queue_data  <= qd_nxt;
      queue_wr_en <= wr_nxt;
      frame_done  <= fd_nxt;
      overflow    <= ovf_nxt;
      line_error  <= le_nxt;
      frame_error <= fe_nxt;
      frame_count <= fc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hi_byte_nxt = hi_byte;
    have_hi_nxt = have_hi;
    sof_nxt     = sof_armed;
    col_nxt     = col;
    row_nxt     = row;
    row_upd     = row;
    qd_nxt      = queue_data;
    wr_nxt      = 1'b0;
    fd_nxt      = 1'b0;
    ovf_nxt     = overflow;
    le_nxt      = line_error;
    fe_nxt      = frame_error;
    fc_nxt      = frame_count;

    if (!init_done) begin
      state_nxt   = WAIT_INIT;
      have_hi_nxt = 1'b0;
    end else begin
      case (state)
        WAIT_INIT: state_nxt = WAIT_FRAME;
        WAIT_FRAME: begin
          if (vsync_fall) begin
            state_nxt   = CAPTURE;
            col_nxt     = '0;
            row_nxt     = '0;
            have_hi_nxt = 1'b0;
            sof_nxt     = 1'b1;
          end
        end
        CAPTURE: begin
          if (s_href) begin
            if (!have_hi) begin
              hi_byte_nxt = s_data;
              have_hi_nxt = 1'b1;
            end else begin
              have_hi_nxt = 1'b0;
              if (col != COL_MAX) col_nxt = col + 11'd1;
              if (col < COL_W && row < ROW_H) begin
                if (queue_full) begin
                  ovf_nxt   = 1'b1;
                  state_nxt = DROP;
                end else begin
                  wr_nxt  = 1'b1;
                  qd_nxt  = {sof_armed, hi_byte, s_data};
                  sof_nxt = 1'b0;
                end
              end
            end
          end else if (href_fall) begin
            have_hi_nxt = 1'b0;
            if (col != COL_W) le_nxt = 1'b1;
            if (row != ROW_MAX) row_upd = row + 10'd1;
            row_nxt = row_upd;
            col_nxt = '0;
          end
          // Frame check sees the row count already bumped by a coincident line end.
          if (vsync_rise && state_nxt == CAPTURE) begin
            if (row_upd != ROW_H) begin
              fe_nxt = 1'b1;
            end else begin
              fc_nxt = frame_count + 8'd1;
              fd_nxt = 1'b1;
            end
            state_nxt = WAIT_FRAME;
          end
        end
        DROP: if (vsync_rise) state_nxt = WAIT_FRAME;
        default: state_nxt = WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_packer.sv
// Directed bench for ov7670_pixel_packer with a 4x2 frame geometry.
module tb_ov7670_pixel_packer;

  logic        clk = 1'b0;
  logic        reset_n, init_done, cam_vsync, cam_href, queue_full;
  logic [7:0]  p_data;
  logic [16:0] queue_data;
  logic        queue_wr_en, frame_done, overflow, line_error, frame_error;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;
  logic [16:0] wr_q[$];
  int fd_cnt = 0;

  ov7670_pixel_packer #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2)) dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .p_data(p_data), .queue_full(queue_full),
    .queue_data(queue_data), .queue_wr_en(queue_wr_en), .frame_done(frame_done),
    .overflow(overflow), .line_error(line_error), .frame_error(frame_error),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (queue_wr_en) wr_q.push_back(queue_data);
    if (frame_done) fd_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    cam_href = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_line(input int n, input logic [7:0] start);
    logic [7:0] b;
    b = start;
    for (int i = 0; i < n; i++) begin
      cam_href = 1'b1;
      p_data   = b;
      b        = b + 8'd1;
      @(negedge clk);
    end
    idle(3);
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    idle(3);
    cam_vsync = 1'b0;
    idle(3);
  endtask

  task automatic frame_end();
    idle(2);
    cam_vsync = 1'b1;
    idle(5);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    fd_cnt = 0;
  endtask

  task automatic check_writes(input string tag, input logic [16:0] exp[$]);
    logic [16:0] obs;
    check({tag, "_count"}, wr_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      obs = (i < wr_q.size()) ? wr_q[i] : 17'h1FFFF;
      check($sformatf("%s_w%0d", tag, i), 32'(obs), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [16:0] exp_full[$];
    logic [16:0] exp_ovf[$];
    logic [16:0] exp_geo[$];
    exp_full = '{17'h10102, 17'h00304, 17'h00506, 17'h00708,
                 17'h0090A, 17'h00B0C, 17'h00D0E, 17'h00F10};
    exp_ovf  = '{17'h10102, 17'h00304};
    exp_geo  = '{17'h10102, 17'h00304, 17'h00506, 17'h00708,
                 17'h01112, 17'h01314, 17'h01516};

    reset_n = 1'b0; init_done = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    p_data = '0; queue_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", queue_wr_en, 0);
    check("rst_data", queue_data, 0);
    check("rst_flags", {frame_done, overflow, line_error, frame_error}, 0);
    check("rst_fcount", frame_count, 0);
    reset_n = 1'b1;

    // 1: good frame
    init_done = 1'b1;
    idle(2);
    clear_mon();
    frame_start();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    frame_end();
    check_writes("t1", exp_full);
    check("t1_frame_done", fd_cnt, 1);
    check("t1_fcount", frame_count, 1);
    check("t1_flags", {overflow, line_error, frame_error}, 0);

    // 2: capture gated by init_done
    init_done = 1'b0;
    clear_mon();
    frame_start();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    frame_end();
    check("t2_no_init_writes", wr_q.size(), 0);
    frame_start();
    init_done = 1'b1;
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    frame_end();
    check("t2_mid_init_writes", wr_q.size(), 0);
    check("t2_frame_done", fd_cnt, 0);
    check("t2_fcount", frame_count, 1);

    // 3: overflow on third pixel, then a clean frame
    clear_mon();
    frame_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) queue_full = 1'b1;
      cam_href = 1'b1;
      p_data   = 8'(i + 1);
      @(negedge clk);
    end
    idle(3);
    send_line(8, 8'h09);
    frame_end();
    queue_full = 1'b0;
    check_writes("t3_ovf", exp_ovf);
    check("t3_overflow", overflow, 1);
    check("t3_frame_done", fd_cnt, 0);
    check("t3_fcount", frame_count, 1);
    clear_mon();
    frame_start();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    frame_end();
    check_writes("t3_next", exp_full);
    check("t3_next_fcount", frame_count, 2);
    check("t3_next_frame_done", fd_cnt, 1);

    // 4: long line then short odd-length line
    clear_mon();
    frame_start();
    send_line(10, 8'h01);
    check("t4_line_error", line_error, 1);
    send_line(7, 8'h11);
    frame_end();
    check_writes("t4", exp_geo);
    check("t4_frame_error", frame_error, 0);
    check("t4_fcount", frame_count, 3);

    // 5: three lines in a frame
    clear_mon();
    frame_start();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    send_line(8, 8'h21);
    frame_end();
    check_writes("t5", exp_full);
    check("t5_frame_error", frame_error, 1);
    check("t5_frame_done", fd_cnt, 0);
    check("t5_fcount", frame_count, 3);

    // 6: reset mid-line, then frame_count wrap
    frame_start();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) reset_n = 1'b0;
      cam_href = 1'b1;
      p_data   = 8'(8'h40 + i);
      @(negedge clk);
    end
    check("t6_rst_wr_en", queue_wr_en, 0);
    check("t6_rst_flags", {overflow, line_error, frame_error, frame_done}, 0);
    check("t6_rst_fcount", frame_count, 0);
    idle(2);
    reset_n = 1'b1;
    idle(3);
    clear_mon();
    for (int f = 0; f < 255; f++) begin
      frame_start();
      send_line(8, 8'h01);
      send_line(8, 8'h09);
      frame_end();
    end
    check("t6_fcount_255", frame_count, 255);
    frame_start();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    frame_end();
    check("t6_fcount_wrap", frame_count, 0);
    check("t6_frame_done_cnt", fd_cnt, 256);
    check("t6_flags", {overflow, line_error, frame_error}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
